gpio_bank: RTL

Parametrised memory-mapped GPIO peripheral on the CPU native memory bus (valid/ready, byte write strobes). It provides NUM_OUT read/write output registers of OUT_W bits each, a debounced input port of NUM_IN pins, and per-pin edge-capture interrupt status with enable, edge select and write-1-to-clear. It replaces fixed 4-register GPIO blocks with a registered single-wait-state handshake, so the block is timing-safe behind the bus decoder.

---
 rtl/gpio_bank.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
// Memory-mapped GPIO peripheral on the CPU native valid/ready bus.
//   - NUM_OUT read/write output registers of OUT_W bits each
//   - NUM_IN input pins: two-flop synchroniser plus per-pin debounce
//   - per-pin edge-capture interrupt status (W1C), enable and edge select
// Every accepted request is acknowledged with a single registered wait state.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   mem_valid         bus request, held by the master until mem_ready
//   mem_addr          byte address, only [5:2] decoded
//   mem_wdata         write data
//   mem_wstrb         byte-lane write strobes, 0 = read
//   mem_rdata         read data, 0 whenever mem_ready = 0
//   mem_ready         one-cycle transfer acknowledge
//   in_pins           asynchronous input pins
//   out_regs          output register i at bits [i*OUT_W +: OUT_W]
//   in_level          debounced input levels
//   irq               |(IRQ_STATUS & IRQ_ENABLE)
//
// Register map (mem_addr[5:2]):
//   0x0-0x7 OUT[i]  0x8 IN  0x9 IRQ_STATUS  0xA IRQ_ENABLE
//   0xB IRQ_EDGE (0 = rising, 1 = falling)  0xC-0xF reserved
// -----------------------------------------------------------------------------
module gpio_bank #(
  parameter int NUM_OUT    = 3,
  parameter int OUT_W      = 4,
  parameter int NUM_IN     = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic [31:0]              mem_rdata,
  output logic                     mem_ready,
  input  logic [NUM_IN-1:0]        in_pins,
  output logic [NUM_OUT*OUT_W-1:0] out_regs,
  output logic [NUM_IN-1:0]        in_level,
  output logic                     irq
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t                        r_state;
  logic                          r_ready;
  logic [31:0]                   r_rdata;
  logic [NUM_OUT-1:0][OUT_W-1:0] r_out;
  logic [NUM_IN-1:0]             r_irq_en;
  logic [NUM_IN-1:0]             r_irq_edge;
  logic [NUM_IN-1:0]             r_irq_status;
  logic [NUM_IN-1:0]             r_sync1;
  logic [NUM_IN-1:0]             r_sync2;
  logic [NUM_IN-1:0]             r_stable;
  logic [NUM_IN-1:0]             r_stable_d;
  logic [NUM_IN-1:0][CW-1:0]     r_cnt;

  logic [3:0]        w_idx;
  logic              w_accept;
  logic              w_write;
  logic [31:0]       w_mask;
  logic [31:0]       w_rdata;
  logic [NUM_IN-1:0] w_rise;
  logic [NUM_IN-1:0] w_fall;
  logic [NUM_IN-1:0] w_set;
  logic [NUM_IN-1:0] w_clr;
  logic              w_unused;

  assign w_idx    = mem_addr[5:2];
  // A request is taken only in IDLE, so the commit happens exactly once.
  assign w_accept = (r_state == ST_IDLE) && mem_valid;
  assign w_write  = w_accept && (mem_wstrb != 4'b0000);
  assign w_mask   = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                     {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign w_unused = ^{mem_addr[31:6], mem_addr[1:0], mem_wdata, w_mask};

  // Debounced level changes; the status bit is set one edge after the change.
  assign w_rise = r_stable & ~r_stable_d;
  assign w_fall = ~r_stable & r_stable_d;
  assign w_set  = (w_rise & ~r_irq_edge) | (w_fall & r_irq_edge);
  assign w_clr  = (w_write && (w_idx == 4'h9))
                  ? (mem_wdata[NUM_IN-1:0] & w_mask[NUM_IN-1:0])
                  : {NUM_IN{1'b0}};

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign out_regs  = r_out;
  assign in_level  = r_stable;
  assign irq       = |(r_irq_status & r_irq_en);

  // Read multiplexer: register contents as they stand before the accept edge.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_idx)
      4'h8:    w_rdata = 32'(r_stable);
      4'h9:    w_rdata = 32'(r_irq_status);
      4'hA:    w_rdata = 32'(r_irq_en);
      4'hB:    w_rdata = 32'(r_irq_edge);
      default: begin
        for (int i = 0; i < NUM_OUT; i++) begin
          w_rdata = w_rdata | ((w_idx == 4'(i)) ? 32'(r_out[i]) : 32'h0000_0000);
        end
      end
    endcase
  end

  // Handshake FSM: one registered wait state, ready pulses for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_valid) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
            r_rdata <= w_rdata;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= 32'h0000_0000;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'h0000_0000;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'h0000_0000;
        end
      endcase
    end
  end

  // Software-writable registers with byte-lane merge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_irq_en   <= '0;
      r_irq_edge <= '0;
    end else if (w_write) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_idx == 4'(i)) begin
          r_out[i] <= (r_out[i] & ~w_mask[OUT_W-1:0])
                    | (mem_wdata[OUT_W-1:0] & w_mask[OUT_W-1:0]);
        end
      end
      if (w_idx == 4'hA) begin
        r_irq_en <= (r_irq_en & ~w_mask[NUM_IN-1:0])
                  | (mem_wdata[NUM_IN-1:0] & w_mask[NUM_IN-1:0]);
      end
      if (w_idx == 4'hB) begin
        r_irq_edge <= (r_irq_edge & ~w_mask[NUM_IN-1:0])
                    | (mem_wdata[NUM_IN-1:0] & w_mask[NUM_IN-1:0]);
      end
    end
  end

  // Interrupt status: a new edge overrides a W1C on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_status <= '0;
    end else begin
      r_irq_status <= (r_irq_status & ~w_clr) | w_set;
    end
  end

  // Input path: synchroniser, then per-pin debounce counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= in_pins;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int p = 0; p < NUM_IN; p++) begin
        if (r_sync2[p] == r_stable[p]) begin
          r_cnt[p] <= '0;
        end else if (r_cnt[p] == CNT_LAST) begin
          // DEB_CYCLES-th consecutive disagreement: accept the new level.
          r_stable[p] <= ~r_stable[p];
          r_cnt[p]    <= '0;
        end else begin
          r_cnt[p] <= r_cnt[p] + CW'(1);
        end
      end
    end
  end

endmodule
